// File: rtl/iq_symbol_slicer_pkg.sv
// Shared constants and state type for the I/Q symbol slicer.
package iq_symbol_slicer_pkg;

   localparam logic MODE_BPSK = 1'b0;
   localparam logic MODE_QPSK = 1'b1;

   typedef enum logic {
      WAIT_I,
      WAIT_Q
   } state_e;

endpackage

// File: rtl/iq_symbol_slicer_if.sv
// Sample/decision bundle between the matched filters, the slicer and the bit sink.
interface iq_symbol_slicer_if #(
   parameter int unsigned DW = 35
);

   logic                 en;
   logic                 sync;
   logic                 mode;
   logic        [DW-2:0] thresh;
   logic signed [DW-1:0] I;
   logic signed [DW-1:0] Q;
   logic                 IQ;
   logic                 bit_valid;
   logic        [1:0]    sym;
   logic                 sym_valid;
   logic                 erasure;

   modport master (
      output en, sync, mode, thresh, I, Q,
      input  IQ, bit_valid, sym, sym_valid, erasure
   );

   modport slave (
      input  en, sync, mode, thresh, I, Q,
      output IQ, bit_valid, sym, sym_valid, erasure
   );

endinterface

// File: rtl/iq_symbol_slicer_mag_below_thresh.sv
// Saturating |x| < thresh compare; the most-negative sample maps to the largest magnitude.
module iq_symbol_slicer_mag_below_thresh #(
   parameter int unsigned DW = 35
) (
   input  logic signed [DW-1:0] x,
   input  logic        [DW-2:0] thresh,
   output logic                 below
);

   logic [DW-2:0] mag;

   always_comb begin
      if (!x[DW-1]) begin
         mag = x[DW-2:0];
      end else if (x[DW-2:0] == '0) begin
         mag = '1;
      end else begin
         mag = ~x[DW-2:0] + 1'b1;
      end
      below = mag < thresh;
   end

endmodule

// File: rtl/iq_symbol_slicer.sv
// Hard-decision BPSK/QPSK symbol slicer: one decision per symbol at a fixed phase,
// parallel symbol output plus an I-then-Q serial bit stream.
module iq_symbol_slicer
   import iq_symbol_slicer_pkg::*;
#(
   parameter int unsigned DW    = 35,
   parameter int unsigned SPS   = 20,
   parameter int unsigned PHASE = 0
) (
   input logic           clk,
   input logic           rst,
   iq_symbol_slicer_if.slave bus
);

   localparam int unsigned CW = $clog2(SPS);
   localparam logic [CW-1:0] CntLast = CW'(SPS - 1);
   localparam logic [CW-1:0] PhaseI  = CW'(PHASE);
   localparam logic [CW-1:0] PhaseQ  = CW'(PHASE + SPS / 2);

   logic [CW-1:0] cnt_q, cnt_d, cnt_eff;
   state_e        state_q, state_d, state_eff;
   logic          mode_q, mode_d, mode_eff;
   logic          dq_q, dq_d;
   logic          iq_q, iq_d;
   logic          bit_valid_q, bit_valid_d;
   logic [1:0]    sym_q, sym_d;
   logic          sym_valid_q, sym_valid_d;
   logic          erasure_q, erasure_d;
   logic          i_below, q_below;

   iq_symbol_slicer_mag_below_thresh #(.DW(DW)) u_mag_i (
      .x      (bus.I),
      .thresh (bus.thresh),
      .below  (i_below)
   );

   iq_symbol_slicer_mag_below_thresh #(.DW(DW)) u_mag_q (
      .x      (bus.Q),
      .thresh (bus.thresh),
      .below  (q_below)
   );

   always_comb begin
      // A resync sample is treated as the first sample of a fresh symbol.
      cnt_eff   = bus.sync ? '0 : cnt_q;
      state_eff = bus.sync ? WAIT_I : state_q;
      mode_eff  = (bus.sync || cnt_q == '0) ? bus.mode : mode_q;

      cnt_d       = cnt_q;
      state_d     = state_q;
      mode_d      = mode_q;
      dq_d        = dq_q;
      iq_d        = iq_q;
      bit_valid_d = 1'b0;
      sym_d       = sym_q;
      sym_valid_d = 1'b0;
      erasure_d   = erasure_q;

      if (bus.en) begin
         if (bus.sync) begin
            cnt_d = CW'(1);
         end else if (cnt_q == CntLast) begin
            cnt_d = '0;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
         mode_d  = mode_eff;
         state_d = state_eff;

         unique case (state_eff)
            WAIT_I: begin
               if (cnt_eff == PhaseI) begin
                  dq_d        = bus.Q[DW-1];
                  iq_d        = bus.I[DW-1];
                  bit_valid_d = 1'b1;
                  sym_valid_d = 1'b1;
                  erasure_d   = i_below | (mode_eff & q_below);
                  if (mode_eff == MODE_QPSK) begin
                     sym_d   = {bus.I[DW-1], bus.Q[DW-1]};
                     state_d = WAIT_Q;
                  end else begin
                     sym_d = {bus.I[DW-1], 1'b0};
                  end
               end
            end
            WAIT_Q: begin
               if (cnt_eff == PhaseQ) begin
                  iq_d        = dq_q;
                  bit_valid_d = 1'b1;
                  state_d     = WAIT_I;
               end
            end
            default: ;
         endcase
      end else if (bus.sync) begin
         // Idle resync drops any pending Q bit.
         cnt_d   = '0;
         state_d = WAIT_I;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q       <= '0;
         state_q     <= WAIT_I;
         mode_q      <= bus.mode;
         dq_q        <= 1'b0;
         iq_q        <= 1'b0;
         bit_valid_q <= 1'b0;
         sym_q       <= 2'b00;
         sym_valid_q <= 1'b0;
         erasure_q   <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         state_q     <= state_d;
         mode_q      <= mode_d;
         dq_q        <= dq_d;
         iq_q        <= iq_d;
         bit_valid_q <= bit_valid_d;
         sym_q       <= sym_d;
         sym_valid_q <= sym_valid_d;
         erasure_q   <= erasure_d;
      end
   end

   assign bus.IQ        = iq_q;
   assign bus.bit_valid = bit_valid_q;
   assign bus.sym       = sym_q;
   assign bus.sym_valid = sym_valid_q;
   assign bus.erasure   = erasure_q;

endmodule

// File: tb/tb_iq_symbol_slicer.sv
// Directed-vector bench for iq_symbol_slicer (DW=35, SPS=20, PHASE=0).
module tb_iq_symbol_slicer;

   localparam int unsigned DW    = 35;
   localparam int unsigned SPS   = 20;
   localparam int unsigned PHASE = 0;

   logic clk = 1'b0;
   logic rst;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   iq_symbol_slicer_if #(.DW(DW)) bus ();

   iq_symbol_slicer #(
      .DW    (DW),
      .SPS   (SPS),
      .PHASE (PHASE)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      bus.en   = 1'b0;
      bus.sync = 1'b0;
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      bus.mode = 1'b1;
      bus.I    = -5;
      bus.Q    = 7;
      bus.en   = 1'b1;
      rst      = 1'b1;
      step();
      n_tests++;
      if (bus.IQ !== 1'b0 || bus.bit_valid !== 1'b0 || bus.sym_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl IQ=%b bit_valid=%b sym_valid=%b want 0 0 0",
                  bus.IQ, bus.bit_valid, bus.sym_valid);
      end
      n_tests++;
      if (bus.sym !== 2'b00 || bus.erasure !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_data sym=%b erasure=%b want 00 0", bus.sym, bus.erasure);
      end
      rst = 1'b0;
      step();
      n_tests++;
      if (bus.sym_valid !== 1'b1 || bus.sym !== 2'b10) begin
         n_fail++;
         $display("FAIL reset_first_decision sym_valid=%b sym=%b want 1 10",
                  bus.sym_valid, bus.sym);
      end
   endtask

   task automatic test_qpsk();
      int nb = 0;
      int ns = 0;
      bus.mode   = 1'b1;
      bus.I      = -5;
      bus.Q      = 7;
      bus.thresh = '0;
      do_reset();
      bus.en = 1'b1;
      for (int k = 0; k < 40; k++) begin
         step();
         if (bus.bit_valid === 1'b1) nb++;
         if (bus.sym_valid === 1'b1) ns++;
         if (k % 20 == 0) begin
            n_tests++;
            if (bus.sym_valid !== 1'b1 || bus.sym !== 2'b10 || bus.IQ !== 1'b1 ||
                bus.bit_valid !== 1'b1) begin
               n_fail++;
               $display("FAIL qpsk_i k=%0d sym_valid=%b sym=%b IQ=%b bit_valid=%b want 1 10 1 1",
                        k, bus.sym_valid, bus.sym, bus.IQ, bus.bit_valid);
            end
         end else if (k % 20 == 5) begin
            n_tests++;
            if (bus.IQ !== 1'b1 || bus.bit_valid !== 1'b0) begin
               n_fail++;
               $display("FAIL qpsk_hold k=%0d IQ=%b bit_valid=%b want 1 0",
                        k, bus.IQ, bus.bit_valid);
            end
         end else if (k % 20 == 10) begin
            n_tests++;
            if (bus.bit_valid !== 1'b1 || bus.IQ !== 1'b0 || bus.sym_valid !== 1'b0) begin
               n_fail++;
               $display("FAIL qpsk_q k=%0d bit_valid=%b IQ=%b sym_valid=%b want 1 0 0",
                        k, bus.bit_valid, bus.IQ, bus.sym_valid);
            end
         end
      end
      n_tests++;
      if (nb != 4 || ns != 2) begin
         n_fail++;
         $display("FAIL qpsk_counts bits=%0d syms=%0d want 4 2", nb, ns);
      end
   endtask

   task automatic test_bpsk();
      int   nb = 0;
      logic e;
      bus.mode   = 1'b0;
      bus.Q      = -7;
      bus.thresh = '0;
      do_reset();
      bus.en = 1'b1;
      for (int s = 0; s < 4; s++) begin
         e     = s[0];
         bus.I = e ? -100 : 100;
         for (int c = 0; c < 20; c++) begin
            step();
            if (bus.bit_valid === 1'b1) nb++;
            if (c == 0) begin
               n_tests++;
               if (bus.sym_valid !== 1'b1 || bus.IQ !== e || bus.sym !== {e, 1'b0}) begin
                  n_fail++;
                  $display("FAIL bpsk_sym s=%0d sym_valid=%b IQ=%b sym=%b want 1 %b %b0",
                           s, bus.sym_valid, bus.IQ, bus.sym, e, e);
               end
            end
         end
      end
      n_tests++;
      if (nb != 4) begin
         n_fail++;
         $display("FAIL bpsk_bits bits=%0d want 4", nb);
      end
   endtask

   task automatic test_en_toggle();
      int       frozen_err = 0;
      int       nbits = 0;
      int       nsyms = 0;
      int       bpos[8];
      int       spos[8];
      logic     prev_iq;
      logic [1:0] prev_sym;
      bus.mode   = 1'b1;
      bus.I      = -5;
      bus.Q      = 7;
      bus.thresh = '0;
      do_reset();
      for (int k = 0; k < 80; k++) begin
         bus.en   = (k % 2 == 0);
         prev_iq  = bus.IQ;
         prev_sym = bus.sym;
         step();
         if (!bus.en && (bus.bit_valid !== 1'b0 || bus.sym_valid !== 1'b0 ||
                         bus.IQ !== prev_iq || bus.sym !== prev_sym)) frozen_err++;
         if (bus.bit_valid === 1'b1 && nbits < 8) begin
            bpos[nbits] = k;
            nbits++;
         end
         if (bus.sym_valid === 1'b1 && nsyms < 8) begin
            spos[nsyms] = k;
            nsyms++;
         end
      end
      n_tests++;
      if (frozen_err != 0) begin
         n_fail++;
         $display("FAIL en_frozen violations=%0d want 0", frozen_err);
      end
      n_tests++;
      if (nsyms != 2 || spos[0] != 0 || spos[1] != 40) begin
         n_fail++;
         $display("FAIL en_sym_spacing count=%0d pos0=%0d pos1=%0d want 2 0 40",
                  nsyms, spos[0], spos[1]);
      end
      n_tests++;
      if (nbits != 4 || bpos[1] != 20 || bpos[3] != 60) begin
         n_fail++;
         $display("FAIL en_bit_spacing count=%0d pos1=%0d pos3=%0d want 4 20 60",
                  nbits, bpos[1], bpos[3]);
      end
      bus.en = 1'b0;
   endtask

   task automatic test_sync();
      int nb = 0;
      bus.mode   = 1'b1;
      bus.I      = -5;
      bus.Q      = -7;
      bus.thresh = '0;
      do_reset();
      bus.en = 1'b1;
      for (int k = 0; k < 7; k++) begin
         step();
         if (k == 0) begin
            n_tests++;
            if (bus.sym_valid !== 1'b1 || bus.sym !== 2'b11) begin
               n_fail++;
               $display("FAIL sync_pre sym_valid=%b sym=%b want 1 11", bus.sym_valid, bus.sym);
            end
         end
      end
      bus.en   = 1'b0;
      bus.sync = 1'b1;
      step();
      n_tests++;
      if (bus.bit_valid !== 1'b0 || bus.sym_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL sync_idle bit_valid=%b sym_valid=%b want 0 0",
                  bus.bit_valid, bus.sym_valid);
      end
      bus.sync = 1'b0;
      bus.en   = 1'b1;
      bus.I    = 5;
      for (int j = 0; j <= 10; j++) begin
         step();
         if (j == 0) begin
            n_tests++;
            if (bus.sym_valid !== 1'b1 || bus.sym !== 2'b01 || bus.IQ !== 1'b0) begin
               n_fail++;
               $display("FAIL sync_redecide sym_valid=%b sym=%b IQ=%b want 1 01 0",
                        bus.sym_valid, bus.sym, bus.IQ);
            end
         end else if (j < 10) begin
            if (bus.bit_valid === 1'b1) nb++;
         end else begin
            n_tests++;
            if (bus.bit_valid !== 1'b1 || bus.IQ !== 1'b1) begin
               n_fail++;
               $display("FAIL sync_q_bit bit_valid=%b IQ=%b want 1 1", bus.bit_valid, bus.IQ);
            end
         end
      end
      n_tests++;
      if (nb != 0) begin
         n_fail++;
         $display("FAIL sync_dropped_q stray_bits=%0d want 0", nb);
      end
   endtask

   task automatic test_erasure();
      logic                 tm[5];
      logic signed [DW-1:0] ti[5];
      logic signed [DW-1:0] tq[5];
      logic        [DW-2:0] tt[5];
      logic                 te[5];
      logic        [1:0]    ts[5];
      tm[0] = 1'b1; ti[0] = -50;             tq[0] = 500; tt[0] = 100;
      te[0] = 1'b1; ts[0] = 2'b10;
      tm[1] = 1'b1; ti[1] = {1'b1, {(DW-1){1'b0}}}; tq[1] = {1'b0, {(DW-1){1'b1}}};
      tt[1] = {(DW-1){1'b1}};
      te[1] = 1'b0; ts[1] = 2'b10;
      tm[2] = 1'b1; ti[2] = 0;               tq[2] = 0;   tt[2] = 0;
      te[2] = 1'b0; ts[2] = 2'b00;
      tm[3] = 1'b0; ti[3] = 500;             tq[3] = 5;   tt[3] = 100;
      te[3] = 1'b0; ts[3] = 2'b00;
      tm[4] = 1'b1; ti[4] = 500;             tq[4] = -5;  tt[4] = 100;
      te[4] = 1'b1; ts[4] = 2'b01;
      for (int c = 0; c < 5; c++) begin
         bus.mode   = tm[c];
         bus.I      = ti[c];
         bus.Q      = tq[c];
         bus.thresh = tt[c];
         do_reset();
         bus.en = 1'b1;
         step();
         n_tests++;
         if (bus.sym_valid !== 1'b1 || bus.erasure !== te[c] || bus.sym !== ts[c]) begin
            n_fail++;
            $display("FAIL erasure case=%0d sym_valid=%b erasure=%b sym=%b want 1 %b %b",
                     c, bus.sym_valid, bus.erasure, bus.sym, te[c], ts[c]);
         end
      end
      bus.thresh = '0;
   endtask

   task automatic test_mode_change();
      int nb = 0;
      bus.mode   = 1'b1;
      bus.I      = -5;
      bus.Q      = -7;
      bus.thresh = '0;
      do_reset();
      bus.en = 1'b1;
      for (int k = 0; k < 40; k++) begin
         if (k == 5) bus.mode = 1'b0;
         step();
         if (bus.bit_valid === 1'b1) nb++;
         if (k == 10) begin
            n_tests++;
            if (bus.bit_valid !== 1'b1 || bus.IQ !== 1'b1) begin
               n_fail++;
               $display("FAIL mode_old_q bit_valid=%b IQ=%b want 1 1", bus.bit_valid, bus.IQ);
            end
         end else if (k == 20) begin
            n_tests++;
            if (bus.sym_valid !== 1'b1 || bus.sym !== 2'b10 || bus.IQ !== 1'b1) begin
               n_fail++;
               $display("FAIL mode_new_bpsk sym_valid=%b sym=%b IQ=%b want 1 10 1",
                        bus.sym_valid, bus.sym, bus.IQ);
            end
         end
      end
      n_tests++;
      if (nb != 3) begin
         n_fail++;
         $display("FAIL mode_bits bits=%0d want 3", nb);
      end
   endtask

   task automatic test_reset_mid();
      int nb = 0;
      bus.mode   = 1'b1;
      bus.I      = -5;
      bus.Q      = -7;
      bus.thresh = '0;
      do_reset();
      bus.en = 1'b1;
      for (int k = 0; k < 5; k++) step();
      rst = 1'b1;
      step();
      n_tests++;
      if (bus.IQ !== 1'b0 || bus.sym !== 2'b00 || bus.bit_valid !== 1'b0 ||
          bus.sym_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_mid IQ=%b sym=%b bit_valid=%b sym_valid=%b want 0 00 0 0",
                  bus.IQ, bus.sym, bus.bit_valid, bus.sym_valid);
      end
      rst   = 1'b0;
      bus.I = 5;
      bus.Q = 5;
      for (int j = 0; j <= 10; j++) begin
         step();
         if (j == 0) begin
            n_tests++;
            if (bus.sym_valid !== 1'b1 || bus.sym !== 2'b00) begin
               n_fail++;
               $display("FAIL rst_mid_restart sym_valid=%b sym=%b want 1 00",
                        bus.sym_valid, bus.sym);
            end
         end else if (j < 10) begin
            if (bus.bit_valid === 1'b1) nb++;
         end else begin
            n_tests++;
            if (bus.bit_valid !== 1'b1 || bus.IQ !== 1'b0 || nb != 0) begin
               n_fail++;
               $display("FAIL rst_mid_q bit_valid=%b IQ=%b stray=%0d want 1 0 0",
                        bus.bit_valid, bus.IQ, nb);
            end
         end
      end
   endtask

   initial begin
      rst        = 1'b1;
      bus.en     = 1'b0;
      bus.sync   = 1'b0;
      bus.mode   = 1'b0;
      bus.thresh = '0;
      bus.I      = '0;
      bus.Q      = '0;
      test_reset();
      test_qpsk();
      test_bpsk();
      test_en_toggle();
      test_sync();
      test_erasure();
      test_mode_change();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
